// File: rtl/bfp_stagescaler.sv
// Per-stage block-floating-point scaler: tracks the stage's max bit width, commits a
// right shift at each stage boundary and accumulates the block exponent (BFP_EXPONENT_EN).
module bfp_stagescaler #(
  parameter int FFT_BFPDW = 5,
  parameter int FFT_DW    = 16,
  parameter int TARGET_BW = FFT_DW - 2,
  parameter int FFT_EXPW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 bw_valid,
  input  logic [FFT_BFPDW-1:0] bw_in,
  input  logic                 stage_end,
  output logic [FFT_BFPDW-1:0] max_bw,
  output logic [FFT_BFPDW-1:0] shift_out,
  output logic                 shift_valid,
  output logic [FFT_EXPW-1:0]  exponent
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [FFT_BFPDW-1:0] TGT = FFT_BFPDW'(TARGET_BW);

  state_t               state_q, state_d;
  logic [FFT_BFPDW-1:0] max_bw_q, max_bw_d;
  logic [FFT_BFPDW-1:0] shift_q, shift_d;
  logic                 shift_vld_q, shift_vld_d;
  logic [FFT_BFPDW-1:0] eff, shamt;

  // A sample arriving in the stage_end cycle still belongs to the closing stage.
  always_comb begin
    eff   = (bw_valid && (bw_in > max_bw_q)) ? bw_in : max_bw_q;
    shamt = (eff > TGT) ? (eff - TGT) : '0;
  end

  always_comb begin
    state_d     = state_q;
    max_bw_d    = max_bw_q;
    shift_d     = shift_q;
    shift_vld_d = 1'b0;
    if (clr) begin
      state_d  = IDLE;
      max_bw_d = '0;
      shift_d  = '0;
    end else if (stage_end) begin
      shift_d     = shamt;
      shift_vld_d = 1'b1;
      max_bw_d    = '0;
      state_d     = bw_valid ? ACCUM : IDLE;
    end else if (bw_valid) begin
      state_d  = ACCUM;
      max_bw_d = eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      max_bw_q    <= '0;
      shift_q     <= '0;
      shift_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      max_bw_q    <= max_bw_d;
      shift_q     <= shift_d;
      shift_vld_q <= shift_vld_d;
    end
  end

  assign max_bw      = max_bw_q;
  assign shift_out   = shift_q;
  assign shift_valid = shift_vld_q;

`ifdef BFP_EXPONENT_EN
  localparam int SW = ((FFT_EXPW > FFT_BFPDW) ? FFT_EXPW : FFT_BFPDW) + 1;
  localparam logic [SW-1:0] EXP_MAX = SW'({FFT_EXPW{1'b1}});

  logic [FFT_EXPW-1:0] exp_q, exp_d;
  logic [SW-1:0]       exp_sum;

  always_comb begin
    exp_sum = SW'(exp_q) + SW'(shamt);
    exp_d   = exp_q;
    if (clr)
      exp_d = '0;
    else if (stage_end)
      exp_d = (exp_sum > EXP_MAX) ? '1 : exp_sum[FFT_EXPW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) exp_q <= '0;
    else     exp_q <= exp_d;
  end

  assign exponent = exp_q;
`else
  assign exponent = '0;
`endif

endmodule

// File: tb/tb_bfp_stagescaler.sv
// Scoreboard bench for bfp_stagescaler: commits are queued at stimulus time and
// popped when shift_valid is sampled.
module tb_bfp_stagescaler;

  localparam int BW = 5;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          bw_valid;
  logic [BW-1:0] bw_in;
  logic          stage_end;
  logic [BW-1:0] max_bw;
  logic [BW-1:0] shift_out;
  logic          shift_valid;
  logic [EW-1:0] exponent;

  typedef struct {
    int sh;
    int ex;
  } commit_t;

  commit_t sb[$];
  int n_chk  = 0;
  int n_fail = 0;
  int m_max  = 0;
  int m_shift = 0;
  int m_exp  = 0;

  bfp_stagescaler #(.FFT_BFPDW(BW), .FFT_DW(16), .FFT_EXPW(EW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .bw_valid(bw_valid), .bw_in(bw_in),
    .stage_end(stage_end), .max_bw(max_bw), .shift_out(shift_out),
    .shift_valid(shift_valid), .exponent(exponent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the model advances at drive time.
  task automatic cyc(input int v, input int b, input int se, input int c);
    int eff, sh;
    @(negedge clk);
    bw_valid = v[0]; bw_in = BW'(b); stage_end = se[0]; clr = c[0];
    if (c != 0) begin
      m_max = 0; m_shift = 0; m_exp = 0;
    end else if (se != 0) begin
      eff = (v != 0 && b > m_max) ? b : m_max;
      sh  = (eff > 14) ? eff - 14 : 0;
      m_shift = sh;
`ifdef BFP_EXPONENT_EN
      m_exp = (m_exp + sh > 15) ? 15 : m_exp + sh;
`endif
      sb.push_back('{sh, m_exp});
      m_max = 0;
    end else if (v != 0 && b > m_max) begin
      m_max = b;
    end
    @(posedge clk); #1;
    chk("max_bw", int'(max_bw), m_max);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    commit_t it;
    #1;
    chk("shift_valid", int'(shift_valid), int'(sb.size() > 0));
    if (sb.size() > 0) begin
      it = sb.pop_front();
      chk("sb_shift", int'(shift_out), it.sh);
      chk("sb_exp", int'(exponent), it.ex);
    end
    chk("shift_out_hold", int'(shift_out), m_shift);
    chk("exponent_hold", int'(exponent), m_exp);
  end

  initial begin
    rst = 1'b1; clr = 1'b0; bw_valid = 1'b0; bw_in = '0; stage_end = 1'b0;
    #1;
    chk("rst_max", int'(max_bw), 0);
    chk("rst_shift", int'(shift_out), 0);
    chk("rst_vld", int'(shift_valid), 0);
    chk("rst_exp", int'(exponent), 0);
    #22 rst = 1'b0;
    idle(4);

    // stage below target: no shift
    cyc(1, 3, 0, 0); cyc(1, 12, 0, 0); cyc(1, 9, 0, 0);
    cyc(0, 0, 1, 0);
    idle(2);

    // 16 coincident with stage_end, then 5 in the commit cycle
    cyc(1, 14, 0, 0);
    cyc(1, 16, 1, 0);
    cyc(1, 5, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);  // back-to-back commits, empty stage

    // ten stages with max 16
    for (int s = 0; s < 10; s++) begin
      cyc(1, 7, 0, 0); cyc(1, 16, 0, 0); cyc(1, 11, 0, 0);
      cyc(0, 0, 1, 0);
    end
    idle(1);

    // random stages
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < 4; k++) cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 16)), 0, 0);
      cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 16)), 1, 0);
    end
    idle(1);

    // clr beats stage_end
    cyc(1, 15, 0, 0);
    chk("pre_clr_max", int'(max_bw), 15);
    cyc(1, 16, 1, 1);
    chk("clr_max", int'(max_bw), 0);
    chk("clr_shift", int'(shift_out), 0);
    chk("clr_exp", int'(exponent), 0);
    cyc(0, 0, 0, 0);

    // async reset mid-stage
    cyc(1, 16, 1, 0);
    cyc(1, 13, 0, 0);
    chk("pre_rst_max", int'(max_bw), 13);
    @(negedge clk);
    bw_valid = 1'b0; stage_end = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_max", int'(max_bw), 0);
    chk("arst_shift", int'(shift_out), 0);
    chk("arst_vld", int'(shift_valid), 0);
    chk("arst_exp", int'(exponent), 0);
    m_max = 0; m_shift = 0; m_exp = 0;
    #1 rst = 1'b0;
    cyc(0, 0, 1, 0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
